// File: rtl/hazard_ctrl_seq.sv
// rtl/hazard_ctrl_seq.sv - pipeline hazard controller: forwarding, load-use, multi-cycle hold, branch flush
// Optional perf counters (stall_cnt/flush_cnt) when HZ_PERF_CNT_EN is defined.
module hazard_ctrl_seq #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] RS1_D,
  input  logic [REG_AW-1:0] RS2_D,
  input  logic [REG_AW-1:0] RS1_E,
  input  logic [REG_AW-1:0] RS2_E,
  input  logic [REG_AW-1:0] Rd_E,
  input  logic [REG_AW-1:0] Rd_M,
  input  logic [REG_AW-1:0] Rd_W,
  input  logic              RegWrite_M,
  input  logic              RegWrite_W,
  input  logic [1:0]        ResultSrc_E,
  input  logic              PCSrc_E,
  input  logic              mc_start_E,
  input  logic              mc_done,
  output logic [1:0]        ForwardA_E,
  output logic [1:0]        ForwardB_E,
  output logic              Stall_F,
  output logic              Stall_D,
  output logic              Stall_E,
  output logic              Flush_D,
  output logic              Flush_E,
  output logic              Flush_M,
  output logic [1:0]        hz_state
`ifdef HZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LD_WAIT = 2'd1,
    ST_MC_BUSY = 2'd2
  } state_t;

  if (LOAD_LAT < 1 || LOAD_LAT > 15 || CNT_W < 1) begin : g_param_check
    $error("hazard_ctrl_seq: LOAD_LAT must be 1..15 and CNT_W >= 1");
  end

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic       w_lu;

  // M has the youngest value, so it wins over W; x0 is never forwarded.
  always_comb begin
    ForwardA_E = 2'b00;
    if (RS1_E != '0 && RegWrite_M && Rd_M == RS1_E) begin
      ForwardA_E = 2'b10;
    end else if (RS1_E != '0 && RegWrite_W && Rd_W == RS1_E) begin
      ForwardA_E = 2'b01;
    end
  end

  always_comb begin
    ForwardB_E = 2'b00;
    if (RS2_E != '0 && RegWrite_M && Rd_M == RS2_E) begin
      ForwardB_E = 2'b10;
    end else if (RS2_E != '0 && RegWrite_W && Rd_W == RS2_E) begin
      ForwardB_E = 2'b01;
    end
  end

  assign w_lu = (ResultSrc_E == 2'b01) && (Rd_E != '0) &&
                ((Rd_E == RS1_D) || (Rd_E == RS2_D));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    Stall_F    = 1'b0;
    Stall_D    = 1'b0;
    Stall_E    = 1'b0;
    Flush_D    = 1'b0;
    Flush_E    = 1'b0;
    Flush_M    = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          // A taken branch kills the would-be consumer, so it beats a load-use stall.
          if (PCSrc_E) begin
            Flush_D = 1'b1;
            Flush_E = 1'b1;
          end else if (mc_start_E && !mc_done) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Stall_E = 1'b1;
            Flush_M = 1'b1;
            w_next  = ST_MC_BUSY;
          end else if (w_lu) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Flush_E = 1'b1;
            if (LOAD_LAT > 1) begin
              w_cnt_next = 4'(LOAD_LAT - 1);
              w_next     = ST_LD_WAIT;
            end
          end
        end
        ST_LD_WAIT: begin
          Stall_F    = 1'b1;
          Stall_D    = 1'b1;
          Flush_E    = 1'b1;
          w_cnt_next = r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            w_next = ST_IDLE;
          end
        end
        ST_MC_BUSY: begin
          if (mc_done) begin
            w_next = ST_IDLE;
          end else begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Stall_E = 1'b1;
            Flush_M = 1'b1;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  assign hz_state = r_state;

`ifdef HZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (Stall_F) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (Flush_D) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule
